// File: rtl/bus_codes_pkg.sv
// ============================================================================
// Module      : bus_codes_pkg
// Description : Bus code, opcode and sequencer state encodings shared by the
//               bus sequencer and the bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_codes_pkg;

    localparam logic [3:0] CODE_NONE  = 4'd0;
    localparam logic [3:0] CODE_A     = 4'd1;
    localparam logic [3:0] CODE_B     = 4'd2;
    localparam logic [3:0] CODE_C     = 4'd3;
    localparam logic [3:0] CODE_D     = 4'd4;
    localparam logic [3:0] CODE_CONST = 4'd5;
    localparam logic [3:0] CODE_TL    = 4'd6;
    localparam logic [3:0] CODE_TH    = 4'd7;
    localparam logic [3:0] CODE_ALU   = 4'd8;
    localparam logic [3:0] CODE_MEM   = 4'd15;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ALU   = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_SWAP  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_SWAP1    = 3'd3,
        ST_SWAP2    = 3'd4
    } seq_state_t;

    // Register-file style codes (A..TH) are the only ones both loadable and drivable.
    function automatic logic is_reg_code(input logic [3:0] code);
        return (code >= CODE_A) && (code <= CODE_TH);
    endfunction

    function automatic logic is_gpr_code(input logic [3:0] code);
        return (code >= CODE_A) && (code <= CODE_D);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_code_check.sv
// ============================================================================
// Module      : bus_code_check
// Description : Combinational legality check of a micro-instruction's
//               (op, dst, src) fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_code_check
    import bus_codes_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [3:0] i_dst,
    input  logic [3:0] i_src,
    output logic       o_illegal
);

    always_comb begin
        o_illegal = 1'b1;
        case (i_op)
            OP_NOP:   o_illegal = 1'b0;
            OP_MOV:   o_illegal = !(is_reg_code(i_dst) &&
                                    (is_reg_code(i_src) || (i_src == CODE_ALU)));
            OP_ALU:   o_illegal = !is_reg_code(i_dst);
            OP_STORE: o_illegal = !((is_reg_code(i_dst) || (i_dst == CODE_MEM)) &&
                                    is_reg_code(i_src));
            OP_SWAP:  o_illegal = !(is_gpr_code(i_dst) && is_gpr_code(i_src));
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bus_sequencer.sv
// ============================================================================
// Module      : bus_sequencer
// Description : Steps 16-bit micro-instructions through 1-3 bus cycles and
//               drives the registered encoded bus control word.
//               Optional memory-wait timeout: define BUS_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sequencer
    import bus_codes_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mem_ready,
    output logic [3:0]  MainAssert,
    output logic [3:0]  MainLoad,
    output logic [1:0]  LhsAssert,
    output logic [1:0]  RhsAssert,
    output logic        busy,
    output logic        illegal,
    output logic        mem_timeout
);

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    seq_state_t state_q, state_d;
    logic [3:0] main_assert_q, main_assert_d;
    logic [3:0] main_load_q, main_load_d;
    logic [1:0] lhs_q, lhs_d;
    logic [1:0] rhs_q, rhs_d;
    logic       busy_q, busy_d;
    logic       illegal_q, illegal_d;
    logic       swap_q, swap_d;
    logic [3:0] src_q, src_d;
    logic [3:0] dst_q, dst_d;
    logic       final_step;
    logic       instr_ill;

    wire [3:0] op_f  = instr[15:12];
    wire [3:0] dst_f = instr[11:8];
    wire [3:0] src_f = instr[7:4];

`ifdef BUS_SEQ_TIMEOUT_EN
    localparam int         CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(MEM_TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    assign mem_timeout = timeout_q;
`else
    assign mem_timeout = 1'b0;
`endif

    bus_code_check u_check (
        .i_op      (op_f),
        .i_dst     (dst_f),
        .i_src     (src_f),
        .o_illegal (instr_ill)
    );

    assign instr_ready = final_step;
    assign MainAssert  = main_assert_q;
    assign MainLoad    = main_load_q;
    assign LhsAssert   = lhs_q;
    assign RhsAssert   = rhs_q;
    assign busy        = busy_q;
    assign illegal     = illegal_q;

    always_comb begin
        state_d       = state_q;
        main_assert_d = main_assert_q;
        main_load_d   = main_load_q;
        lhs_d         = lhs_q;
        rhs_d         = rhs_q;
        illegal_d     = 1'b0;
        swap_d        = swap_q;
        src_d         = src_q;
        dst_d         = dst_q;
`ifdef BUS_SEQ_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE:     final_step = 1'b1;
            ST_EXEC:     final_step = !swap_q;
            ST_WAIT_MEM: final_step = mem_ready;
            ST_SWAP2:    final_step = 1'b1;
            default:     final_step = 1'b0;
        endcase

        if (final_step) begin
            // Either go idle or load the next op's step-1 codes with no bubble.
            state_d       = ST_IDLE;
            main_assert_d = CODE_NONE;
            main_load_d   = CODE_NONE;
            lhs_d         = 2'd0;
            rhs_d         = 2'd0;
            swap_d        = 1'b0;
            if (instr_valid) begin
                state_d = ST_EXEC;
                if (instr_ill) begin
                    illegal_d = 1'b1;
                end else begin
                    case (op_f)
                        OP_MOV: begin
                            main_assert_d = src_f;
                            main_load_d   = dst_f;
                        end
                        OP_ALU: begin
                            main_assert_d = CODE_ALU;
                            main_load_d   = dst_f;
                            lhs_d         = instr[3:2];
                            rhs_d         = instr[1:0];
                        end
                        OP_STORE: begin
                            state_d       = ST_WAIT_MEM;
                            main_assert_d = src_f;
                            main_load_d   = CODE_MEM;
`ifdef BUS_SEQ_TIMEOUT_EN
                            cnt_d         = '0;
`endif
                        end
                        OP_SWAP: begin
                            main_assert_d = src_f;
                            main_load_d   = CODE_TL;
                            swap_d        = 1'b1;
                            src_d         = src_f;
                            dst_d         = dst_f;
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            case (state_q)
                ST_EXEC: begin
                    state_d       = ST_SWAP1;
                    main_assert_d = dst_q;
                    main_load_d   = src_q;
                end
                ST_SWAP1: begin
                    state_d       = ST_SWAP2;
                    main_assert_d = CODE_TL;
                    main_load_d   = dst_q;
                end
`ifdef BUS_SEQ_TIMEOUT_EN
                ST_WAIT_MEM: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == C_TIMEOUT) begin
                        state_d       = ST_IDLE;
                        main_assert_d = CODE_NONE;
                        main_load_d   = CODE_NONE;
                        timeout_d     = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= ST_IDLE;
            main_assert_q <= CODE_NONE;
            main_load_q   <= CODE_NONE;
            lhs_q         <= 2'd0;
            rhs_q         <= 2'd0;
            busy_q        <= 1'b0;
            illegal_q     <= 1'b0;
            swap_q        <= 1'b0;
            src_q         <= 4'd0;
            dst_q         <= 4'd0;
`ifdef BUS_SEQ_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            main_assert_q <= main_assert_d;
            main_load_q   <= main_load_d;
            lhs_q         <= lhs_d;
            rhs_q         <= rhs_d;
            busy_q        <= busy_d;
            illegal_q     <= illegal_d;
            swap_q        <= swap_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
`ifdef BUS_SEQ_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// ============================================================================
// Module      : tb_bus_sequencer
// Description : Directed scoreboard bench for bus_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_sequencer;

    logic        clk;
    logic        reset_in;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ready;
    logic [3:0]  MainAssert;
    logic [3:0]  MainLoad;
    logic [1:0]  LhsAssert;
    logic [1:0]  RhsAssert;
    logic        busy;
    logic        illegal;
    logic        mem_timeout;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] l;
        logic [1:0] lhs;
        logic [1:0] rhs;
        logic       bsy;
        logic       ill;
        logic       mt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bus_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_in    (reset_in),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mem_ready   (mem_ready),
        .MainAssert  (MainAssert),
        .MainLoad    (MainLoad),
        .LhsAssert   (LhsAssert),
        .RhsAssert   (RhsAssert),
        .busy        (busy),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".assert"}, {4'd0, MainAssert}, {4'd0, e.a});
        chk({tag, ".load"},   {4'd0, MainLoad},   {4'd0, e.l});
        chk({tag, ".lhs"},    {6'd0, LhsAssert},  {6'd0, e.lhs});
        chk({tag, ".rhs"},    {6'd0, RhsAssert},  {6'd0, e.rhs});
        chk({tag, ".busy"},   {7'd0, busy},       {7'd0, e.bsy});
        chk({tag, ".illegal"},{7'd0, illegal},    {7'd0, e.ill});
        chk({tag, ".mem_timeout"}, {7'd0, mem_timeout}, {7'd0, e.mt});
        chk({tag, ".not_both_mem"},
            {7'd0, (MainAssert == 4'd15) && (MainLoad == 4'd15)}, 8'd0);
    endtask

    // Called at a negedge: drive one cycle, check ready now, check outputs after the edge.
    task automatic tick(input string tag, input logic v, input logic [15:0] ins,
                        input logic mr, input logic rdy,
                        input logic [3:0] a, input logic [3:0] l,
                        input logic [1:0] lhs, input logic [1:0] rhs,
                        input logic bsy, input logic ill, input logic mt);
        exp_t e;
        instr_valid = v;
        instr       = ins;
        mem_ready   = mr;
        #1;
        chk({tag, ".ready"}, {7'd0, instr_ready}, {7'd0, rdy});
        e = '{a: a, l: l, lhs: lhs, rhs: rhs, bsy: bsy, ill: ill, mt: mt};
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            chk_outputs(tag, sb.pop_front());
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk_outputs(tag, exp_t'(0));
        chk({tag, ".ready"}, {7'd0, instr_ready}, 8'd1);
    endtask

    initial begin
        reset_in    = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        mem_ready   = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");
        reset_in = 1'b1;
        @(negedge clk);

        // MOV then ALU back-to-back, then drain
        tick("mov",      1, 16'h1210, 0, 1, 4'd1, 4'd2, 2'd0, 2'd0, 1, 0, 0);
        tick("alu",      1, 16'h2301, 0, 1, 4'd8, 4'd3, 2'd0, 2'd1, 1, 0, 0);
        tick("drain1",   0, 16'h0000, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 0, 0, 0);
        tick("alu2",     1, 16'h270E, 0, 1, 4'd8, 4'd7, 2'd3, 2'd2, 1, 0, 0);
        tick("mov_alu",  1, 16'h1180, 0, 1, 4'd8, 4'd1, 2'd0, 2'd0, 1, 0, 0);
        tick("nop",      1, 16'h0000, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 1, 0, 0);

        // STORE: accept-cycle mem_ready ignored; waiting SWAP held while not ready
        tick("store_acc",1, 16'h3F40, 1, 1, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("store_w1", 1, 16'h4210, 0, 0, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("store_w2", 1, 16'h4210, 0, 0, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("store_w3", 1, 16'h4210, 0, 0, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);

        // Final STORE cycle hands over to SWAP A,B
        tick("swap_s1",  1, 16'h4210, 1, 1, 4'd1, 4'd6, 2'd0, 2'd0, 1, 0, 0);
        tick("swap_s2",  0, 16'h0000, 0, 0, 4'd2, 4'd1, 2'd0, 2'd0, 1, 0, 0);
        tick("swap_s3",  0, 16'h0000, 0, 0, 4'd6, 4'd2, 2'd0, 2'd0, 1, 0, 0);

        // Illegal instructions execute as one-cycle NOPs
        tick("ill_op",   1, 16'h7000, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 1, 1, 0);
        tick("ill_dst",  1, 16'h1810, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 1, 1, 0);
        tick("ill_swap", 1, 16'h4150, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 1, 1, 0);
        tick("drain2",   0, 16'h0000, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 0, 0, 0);

        // Reset asserted during SWAP1 aborts the op
        tick("swp2_s1",  1, 16'h4320, 0, 1, 4'd2, 4'd6, 2'd0, 2'd0, 1, 0, 0);
        tick("swp2_s2",  0, 16'h0000, 0, 0, 4'd3, 4'd2, 2'd0, 2'd0, 1, 0, 0);
        reset_in = 1'b0;
        #1;
        chk_reset_state("rst_async");
        @(negedge clk);
        chk_reset_state("rst_hold");
        reset_in = 1'b1;
        tick("post_rst", 1, 16'h1230, 0, 1, 4'd3, 4'd2, 2'd0, 2'd0, 1, 0, 0);
        tick("drain3",   0, 16'h0000, 0, 1, 4'd0, 4'd0, 2'd0, 2'd0, 0, 0, 0);

`ifdef BUS_SEQ_TIMEOUT_EN
        // MEM_TIMEOUT=4: four wait cycles, then a timeout pulse in IDLE
        tick("to_acc",   1, 16'h3F40, 0, 1, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("to_w1",    0, 16'h0000, 0, 0, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("to_w2",    0, 16'h0000, 0, 0, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("to_w3",    0, 16'h0000, 0, 0, 4'd4, 4'd15, 2'd0, 2'd0, 1, 0, 0);
        tick("to_w4",    0, 16'h0000, 0, 0, 4'd0, 4'd0,  2'd0, 2'd0, 0, 0, 1);
        tick("to_after", 0, 16'h0000, 0, 1, 4'd0, 4'd0,  2'd0, 2'd0, 0, 0, 0);
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
